// File: rtl/sequencer_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sequencer_ram_arbiter
//   Front-end for the single-port sequencer RAM. Two Avalon-MM masters share
//   the RAM's one port:
//     M0 - instruction port, read only
//     M1 - data port, read/write
//   Arbitration alternates on contention and grants a lone requester in the
//   same cycle, so the RAM can accept one command every cycle. Read data comes
//   back through a valid/tag pipeline that matches the RAM's 1-cycle latency,
//   plus an optional output register (REG_RSP). M1 writes below PROTECT_WORDS
//   are accepted but dropped, and are recorded in a sticky flag and a
//   saturating counter.
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   m0_address/read                 M0 command
//   m0_waitrequest                  M0 stall (low = command accepted)
//   m0_readdata/readdatavalid       M0 read return
//   m1_address/read/write           M1 command (read and write never together)
//   m1_byteenable/writedata         M1 write lanes and data
//   m1_waitrequest                  M1 stall
//   m1_readdata/readdatavalid       M1 read return
//   ram_address/byteenable/
//   ram_chipselect/write/writedata  command to the RAM
//   ram_clken                       RAM clock enable, tied high
//   ram_readdata                    RAM q, valid the cycle after the address
//   err_clear                       clears prot_err / prot_err_cnt
//   prot_err                        sticky: a protected M1 write was dropped
//   prot_err_cnt                    dropped-write count, saturates at 255
// ---------------------------------------------------------------------------
module sequencer_ram_arbiter #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int BE_W          = 4,
  parameter int PROTECT_WORDS = 0,
  parameter int REG_RSP       = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  input  logic              err_clear,
  output logic              prot_err,
  output logic [7:0]        prot_err_cnt
);

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  // Read-return pipeline depth: one stage for the RAM latency, one more when
  // the returned data is registered.
  localparam int L_DEPTH = 1 + REG_RSP;

  owner_t              r_last_grant;
  logic [L_DEPTH-1:0]  r_vld;
  logic [L_DEPTH-1:0]  r_tag;          // 1 = read belongs to M1
  logic                r_prot_err;
  logic [7:0]          r_prot_cnt;

  logic                w_m1_req;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_rd_gnt;
  logic                w_prot_addr;
  logic                w_prot_hit;
  logic                w_ret_vld;
  logic                w_ret_tag;

  assign w_m1_req = m1_read | m1_write;

  // -------------------------------------------------------------------------
  // Arbitration. On contention the master that did not win last time gets
  // the port; r_last_grant resets to M1 so M0 wins the first tie. No grant
  // while reset is held, which also keeps both waitrequests high.
  // -------------------------------------------------------------------------
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset_n) begin
      if (m0_read && w_m1_req) begin
        w_gnt0 = (r_last_grant == OWNER_M1);
        w_gnt1 = (r_last_grant == OWNER_M0);
      end else begin
        w_gnt0 = m0_read;
        w_gnt1 = w_m1_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= OWNER_M1;
    end else if (w_gnt0) begin
      r_last_grant <= OWNER_M0;
    end else if (w_gnt1) begin
      r_last_grant <= OWNER_M1;
    end
  end

  assign m0_waitrequest = ~w_gnt0;
  assign m1_waitrequest = ~w_gnt1;

  // -------------------------------------------------------------------------
  // Write protection of the low instruction region.
  // -------------------------------------------------------------------------
  generate
    if (PROTECT_WORDS > 0) begin : g_prot
      // Clamp to the address space so the limit always fits ADDR_W+1 bits.
      localparam int L_LIM = (PROTECT_WORDS > (1 << ADDR_W)) ? (1 << ADDR_W) : PROTECT_WORDS;
      localparam logic [ADDR_W:0] L_PROT_LIM = L_LIM[ADDR_W:0];
      assign w_prot_addr = ({1'b0, m1_address} < L_PROT_LIM);
    end else begin : g_noprot
      assign w_prot_addr = 1'b0;
    end
  endgenerate

  // A protected write is still accepted (waitrequest low) but never reaches
  // the RAM.
  assign w_prot_hit = w_gnt1 & m1_write & w_prot_addr;
  assign w_rd_gnt   = w_gnt0 | (w_gnt1 & m1_read);

  always_comb begin
    ram_address    = w_gnt0 ? m0_address : m1_address;
    ram_byteenable = (w_gnt1 && m1_write) ? m1_byteenable : {BE_W{1'b1}};
    ram_writedata  = m1_writedata;
    ram_chipselect = (w_gnt0 | w_gnt1) & ~w_prot_hit;
    ram_write      = w_gnt1 & m1_write & ~w_prot_addr;
  end

  assign ram_clken = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prot_err <= 1'b0;
      r_prot_cnt <= '0;
    end else if (w_prot_hit) begin
      // A violation in the same cycle as a clear restarts the count at one.
      r_prot_err <= 1'b1;
      if (err_clear) begin
        r_prot_cnt <= 8'd1;
      end else if (r_prot_cnt != 8'hFF) begin
        r_prot_cnt <= r_prot_cnt + 8'd1;
      end
    end else if (err_clear) begin
      r_prot_err <= 1'b0;
      r_prot_cnt <= '0;
    end
  end

  assign prot_err     = r_prot_err;
  assign prot_err_cnt = r_prot_cnt;

  // -------------------------------------------------------------------------
  // Read return. Stage 0 lines up with the RAM q; the last stage drives the
  // readdatavalid outputs. Reset flushes anything in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_vld[0] <= w_rd_gnt;
      r_tag[0] <= w_gnt1;
      for (int i = 1; i < L_DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_ret_vld = r_vld[L_DEPTH-1];
  assign w_ret_tag = r_tag[L_DEPTH-1];

  assign m0_readdatavalid = w_ret_vld & ~w_ret_tag;
  assign m1_readdatavalid = w_ret_vld &  w_ret_tag;

  generate
    if (REG_RSP != 0) begin : g_reg_rsp
      logic [DATA_W-1:0] w_rdata [2];
      // One data register per master: only the tagged master's register
      // loads, so the other keeps its last returned word.
      for (genvar gi = 0; gi < 2; gi++) begin : g_m
        logic [DATA_W-1:0] r_rdata;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_rdata <= '0;
          end else if (r_vld[0] && (r_tag[0] == 1'(gi))) begin
            r_rdata <= ram_readdata;
          end
        end
        assign w_rdata[gi] = r_rdata;
      end
      assign m0_readdata = w_rdata[0];
      assign m1_readdata = w_rdata[1];
    end else begin : g_pass_rsp
      assign m0_readdata = ram_readdata;
      assign m1_readdata = ram_readdata;
    end
  endgenerate

endmodule

// File: tb/tb_sequencer_ram_arbiter.sv
`timescale 1ns/1ps
// Three arbiter instances share one stimulus stream:
//   cfg0: REG_RSP=1, no protection
//   cfg1: REG_RSP=0, no protection
//   cfg2: REG_RSP=1, PROTECT_WORDS=64
// Each instance has its own behavioural RAM and its own reference model.
module tb_sequencer_ram_arbiter;

  localparam int NCFG = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [8:0]  m0_address;
  logic        m0_read;
  logic [8:0]  m1_address;
  logic        m1_read;
  logic        m1_write;
  logic [3:0]  m1_byteenable;
  logic [31:0] m1_writedata;
  logic        err_clear;

  wire         m0_wait  [NCFG];
  wire [31:0]  m0_rdat  [NCFG];
  wire         m0_rdv   [NCFG];
  wire         m1_wait  [NCFG];
  wire [31:0]  m1_rdat  [NCFG];
  wire         m1_rdv   [NCFG];
  wire [8:0]   ram_addr [NCFG];
  wire [3:0]   ram_be   [NCFG];
  wire         ram_cs   [NCFG];
  wire         ram_wr   [NCFG];
  wire [31:0]  ram_wd   [NCFG];
  wire         ram_ce   [NCFG];
  wire         perr     [NCFG];
  wire [7:0]   pcnt     [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          m;
    logic [31:0] d;
    int          due;
  } rsp_t;

  task automatic chk(input int c, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL cfg%0d %s: actual=%h required=%h t=%0t", c, nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A00_0000 ^ (a * 32'h0001_0203);
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int P_REG  = (gi == 1) ? 0 : 1;
    localparam int P_PROT = (gi == 2) ? 64 : 0;

    logic [31:0] ram_q;
    logic [31:0] ram_mem [512];

    sequencer_ram_arbiter #(
      .ADDR_W(9), .DATA_W(32), .BE_W(4),
      .PROTECT_WORDS(P_PROT), .REG_RSP(P_REG)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read),
      .m0_waitrequest(m0_wait[gi]), .m0_readdata(m0_rdat[gi]), .m0_readdatavalid(m0_rdv[gi]),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_wait[gi]), .m1_readdata(m1_rdat[gi]), .m1_readdatavalid(m1_rdv[gi]),
      .ram_address(ram_addr[gi]), .ram_byteenable(ram_be[gi]), .ram_chipselect(ram_cs[gi]),
      .ram_write(ram_wr[gi]), .ram_writedata(ram_wd[gi]), .ram_clken(ram_ce[gi]),
      .ram_readdata(ram_q),
      .err_clear(err_clear), .prot_err(perr[gi]), .prot_err_cnt(pcnt[gi])
    );

    // Behavioural single-port RAM, 1-cycle read latency, old data on q.
    initial for (int i = 0; i < 512; i++) ram_mem[i] = init_word(i);
    always @(posedge clk) begin
      if (ram_cs[gi] && ram_ce[gi]) begin
        if (ram_wr[gi]) begin
          for (int b = 0; b < 4; b++) begin
            if (ram_be[gi][b]) ram_mem[ram_addr[gi]][8*b +: 8] <= ram_wd[gi][8*b +: 8];
          end
        end
        ram_q <= ram_mem[ram_addr[gi]];
      end
    end

    // Reference model: shadow memory, expected-return queue with due cycles,
    // alternating-priority arbitration and the protection counter.
    logic [31:0] shadow [512];
    logic [31:0] last_rd [2];
    rsp_t        exp_q [$];
    bit          last_m1 = 1'b1;
    bit          s_err = 1'b0;
    int          s_cnt = 0;
    int          cyc = 0;

    initial begin
      for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
      last_rd[0] = '0;
      last_rd[1] = '0;
    end

    always @(negedge clk) begin
      bit          g0, g1, m1req, prot, e_cs, e_wr, ev0, ev1;
      logic [31:0] hold0, hold1;
      rsp_t        e;
      cyc++;
      if (!reset_n) begin
        hold0 = (P_REG != 0) ? 32'h0 : ram_q;
        hold1 = hold0;
        chk(gi, "rst_m0_wait", m0_wait[gi], 1);
        chk(gi, "rst_m1_wait", m1_wait[gi], 1);
        chk(gi, "rst_ram_cs", ram_cs[gi], 0);
        chk(gi, "rst_ram_wr", ram_wr[gi], 0);
        chk(gi, "rst_m0_rdv", m0_rdv[gi], 0);
        chk(gi, "rst_m1_rdv", m1_rdv[gi], 0);
        chk(gi, "rst_m0_rdata", m0_rdat[gi], hold0);
        chk(gi, "rst_m1_rdata", m1_rdat[gi], hold1);
        chk(gi, "rst_prot_err", perr[gi], 0);
        chk(gi, "rst_prot_cnt", pcnt[gi], 0);
        exp_q.delete();
        last_m1 = 1'b1;
        s_err = 1'b0;
        s_cnt = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
      end else begin
        m1req = m1_read || m1_write;
        g0    = m0_read && (!m1req || last_m1);
        g1    = m1req && !g0;
        prot  = g1 && m1_write && (int'(m1_address) < P_PROT);
        e_wr  = g1 && m1_write && !prot;
        e_cs  = (g0 || g1) && !prot;
        chk(gi, "m0_waitrequest", m0_wait[gi], !g0);
        chk(gi, "m1_waitrequest", m1_wait[gi], !g1);
        chk(gi, "ram_chipselect", ram_cs[gi], e_cs);
        chk(gi, "ram_write", ram_wr[gi], e_wr);
        chk(gi, "ram_clken", ram_ce[gi], 1);
        if (e_cs) chk(gi, "ram_address", ram_addr[gi], g0 ? m0_address : m1_address);
        if (e_wr) begin
          chk(gi, "ram_byteenable_wr", ram_be[gi], m1_byteenable);
          chk(gi, "ram_writedata", ram_wd[gi], m1_writedata);
        end else if (e_cs) begin
          chk(gi, "ram_byteenable_rd", ram_be[gi], 4'hF);
        end

        ev0 = (exp_q.size() > 0) && (exp_q[0].due == cyc) && !exp_q[0].m;
        ev1 = (exp_q.size() > 0) && (exp_q[0].due == cyc) &&  exp_q[0].m;
        chk(gi, "m0_readdatavalid", m0_rdv[gi], ev0);
        chk(gi, "m1_readdatavalid", m1_rdv[gi], ev1);
        if (ev0 || ev1) begin
          last_rd[exp_q[0].m] = exp_q[0].d;
          void'(exp_q.pop_front());
        end
        // Registered responses hold the last word per master; pass-through
        // responses show the RAM q directly.
        hold0 = (P_REG != 0) ? last_rd[0] : ram_q;
        hold1 = (P_REG != 0) ? last_rd[1] : ram_q;
        if (ev0) hold0 = last_rd[0];
        if (ev1) hold1 = last_rd[1];
        chk(gi, "m0_readdata", m0_rdat[gi], hold0);
        chk(gi, "m1_readdata", m1_rdat[gi], hold1);
        chk(gi, "prot_err", perr[gi], s_err);
        chk(gi, "prot_err_cnt", pcnt[gi], s_cnt);

        if (g0 || g1) last_m1 = g1;
        if (g0) begin
          e.m = 1'b0; e.d = shadow[m0_address]; e.due = cyc + 1 + P_REG;
          exp_q.push_back(e);
        end
        if (g1 && m1_read) begin
          e.m = 1'b1; e.d = shadow[m1_address]; e.due = cyc + 1 + P_REG;
          exp_q.push_back(e);
        end
        if (e_wr) begin
          for (int b = 0; b < 4; b++) begin
            if (m1_byteenable[b]) shadow[m1_address][8*b +: 8] = m1_writedata[8*b +: 8];
          end
        end
        if (prot) begin
          s_err = 1'b1;
          s_cnt = err_clear ? 1 : ((s_cnt < 255) ? s_cnt + 1 : 255);
        end else if (err_clear) begin
          s_err = 1'b0;
          s_cnt = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus. Inputs change 1 ns after the rising edge; checks on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0; err_clear = 1'b0;
  endtask

  task automatic m1_wr_cmd(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    idle_in();
    m1_write = 1'b1; m1_address = a; m1_writedata = d; m1_byteenable = be;
    $display("t=%0t M1 WR addr=%h data=%h be=%b", $time, a, d, be);
  endtask

  task automatic m1_rd_cmd(input logic [8:0] a);
    idle_in();
    m1_read = 1'b1; m1_address = a;
    $display("t=%0t M1 RD addr=%h", $time, a);
  endtask

  initial begin
    logic [7:0] lb;
    reset_n = 1'b0; m0_address = '0; m1_address = '0;
    m1_byteenable = '0; m1_writedata = '0;
    idle_in();
    repeat (3) step();
    reset_n = 1'b1;

    // Reset release, no requests
    $display("t=%0t IDLE after reset release", $time);
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      chk(c, "t1_m0_wait", m0_wait[c], 1);
      chk(c, "t1_m1_wait", m1_wait[c], 1);
      chk(c, "t1_ram_cs", ram_cs[c], 0);
      chk(c, "t1_prot_cnt", pcnt[c], 0);
    end
    step();

    // Byte write then read back
    m1_wr_cmd(9'h010, 32'h0000_00A5, 4'b0001);
    @(negedge clk);
    chk(0, "t2_wr_ram_write", ram_wr[0], 1);
    chk(2, "t2_wr_protected", ram_wr[2], 0);
    step();
    m1_rd_cmd(9'h010);
    @(negedge clk);
    chk(0, "t2_rd_accept", m1_wait[0], 0);
    step();
    idle_in();
    @(negedge clk);
    chk(1, "t2_rdv_at_n1", m1_rdv[1], 1);
    lb = m1_rdat[1][7:0];
    chk(1, "t2_lowbyte_n1", lb, 8'hA5);
    chk(0, "t2_no_rdv_at_n1", m1_rdv[0], 0);
    step();
    @(negedge clk);
    chk(0, "t2_rdv_at_n2", m1_rdv[0], 1);
    chk(0, "t2_word_n2", m1_rdat[0], 32'h5A10_20A5);
    step();

    // Both masters read every cycle; addresses advance after each acceptance
    for (int k = 0; k < 8; k++) begin
      m0_read = 1'b1; m0_address = 9'(256 + (k + 1) / 2);
      m1_read = 1'b1; m1_address = 9'(16 + k / 2);
      $display("t=%0t M0 RD addr=%h / M1 RD addr=%h", $time, m0_address, m1_address);
      @(negedge clk);
      if (k == 0) begin
        chk(0, "t3_first_tie_m0", m0_wait[0], 0);
        chk(0, "t3_first_tie_m1", m1_wait[0], 1);
      end
      if (k == 2) begin
        chk(0, "t3_first_m0_rdv", m0_rdv[0], 1);
        chk(0, "t3_first_m0_data", m0_rdat[0], 32'h5B02_0300);
      end
      step();
    end
    idle_in();
    repeat (3) step();

    // Read then write to the same address: old data returns
    m1_rd_cmd(9'h030);
    @(negedge clk);
    step();
    m1_wr_cmd(9'h030, 32'h1122_3344, 4'hF);
    @(negedge clk);
    step();
    idle_in();
    @(negedge clk);
    chk(0, "t_rw_old_data", m1_rdat[0], 32'h5A30_6090);
    step();
    step();

    // Protected write
    err_clear = 1'b1;
    $display("t=%0t ERR_CLEAR", $time);
    step();
    m1_wr_cmd(9'h020, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    chk(2, "t4_prot_accept", m1_wait[2], 0);
    chk(2, "t4_prot_ram_write", ram_wr[2], 0);
    step();
    idle_in();
    @(negedge clk);
    chk(2, "t4_prot_err", perr[2], 1);
    chk(2, "t4_prot_cnt1", pcnt[2], 1);
    step();
    m1_rd_cmd(9'h020);
    step();
    idle_in();
    step();
    @(negedge clk);
    chk(2, "t4_readback_unchanged", m1_rdat[2], 32'h5A20_4060);
    step();
    for (int k = 0; k < 300; k++) begin
      m1_wr_cmd(9'h020, 32'(k), 4'hF);
      step();
    end
    idle_in();
    @(negedge clk);
    chk(2, "t4_cnt_saturated", pcnt[2], 255);
    step();
    err_clear = 1'b1;
    $display("t=%0t ERR_CLEAR", $time);
    step();
    err_clear = 1'b0;
    @(negedge clk);
    chk(2, "t4_clear_err", perr[2], 0);
    chk(2, "t4_clear_cnt", pcnt[2], 0);
    step();

    // Clear in the same cycle as a violation
    for (int k = 0; k < 3; k++) begin
      m1_wr_cmd(9'h004, 32'hDEAD_0000 + 32'(k), 4'hF);
      step();
    end
    m1_wr_cmd(9'h005, 32'hBEEF_0000, 4'hF);
    err_clear = 1'b1;
    $display("t=%0t ERR_CLEAR with protected write", $time);
    step();
    idle_in();
    @(negedge clk);
    chk(2, "t5_err_wins", perr[2], 1);
    chk(2, "t5_cnt_one", pcnt[2], 1);
    step();

    // Reset one cycle after a read grant
    m0_read = 1'b1; m0_address = 9'h005;
    $display("t=%0t M0 RD addr=%h then reset", $time, m0_address);
    step();
    idle_in();
    reset_n = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) chk(c, "t6_wait_in_reset", m0_wait[c], 1);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) chk(c, "t6_no_rdv_after_reset", m0_rdv[c], 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
